cluster_expander: RTL
=====================

Name: cluster_expander

Overview:
- Inverse of the cluster-size counting path: takes a serial stream of encoded clusters (address, count) for one bunch crossing and repaints them into an s-bit bitmap.
- Sits downstream of the cluster packer on the readout side.
- Uses: emulator/loopback checking of the cluster finder; monitoring of the trigger path in s-bit space.
- Output bitmap is double-buffered behind a valid/ready handshake.

Parameters:
- NUM_SBITS, 1536, width of the reconstructed s-bit map.
- ADR_BITS, 11, cluster address width.
- CNT_BITS, 3, cluster count width. Count = cluster size minus 1, so sizes are 1..8.
- MAX_CLUSTERS, 16, clusters accepted per frame; extras are dropped.

Ports:
- clock, in, 1, single clock.
- reset_n, in, 1, synchronous active-low reset.
- en, in, 1, clock enable; all state is frozen when low.
- cluster_valid, in, 1, cluster beat valid.
- cluster_ready, out, 1, expander can accept a beat.
- cluster_adr, in, ADR_BITS, first s-bit of the cluster.
- cluster_cnt, in, CNT_BITS, additional consecutive s-bits after cluster_adr.
- frame_end, in, 1, qualified by cluster_valid; marks the last beat of the frame.
- sbits, out, NUM_SBITS, reconstructed bitmap.
- sbits_valid, out, 1, bitmap available.
- sbits_ready, in, 1, downstream accepts the bitmap.
- overflow, out, 1, one-cycle pulse when a frame exceeded MAX_CLUSTERS.
- overlap, out, 1, sticky overlap flag (see Optional Feature).

Behaviour:
- Reset (reset_n low at clock edge): all outputs 0 (sbits, sbits_valid, overflow, overlap); accumulator and per-frame cluster counter cleared; state = ACCUM. Reset mid-frame discards the partial frame and any pending output.
- Beat accepted when cluster_valid & cluster_ready & en.
- Painting an accepted beat:
  - Sets accumulator bits cluster_adr .. cluster_adr+cluster_cnt.
  - Bits at index >= NUM_SBITS are clipped, with no wrap to bit 0.
  - cluster_adr >= NUM_SBITS (including the invalid sentinel 0x7FF) paints nothing, but the beat still counts as accepted and frame_end is honoured.
- Cluster limit: beats beyond MAX_CLUSTERS in one frame paint nothing. overflow pulses for 1 cycle, on the cycle after that frame's frame_end is accepted.
- State ACCUM: cluster_ready = 1.
  - On an accepted beat with frame_end: if the output buffer is empty, or being drained this cycle (sbits_valid & sbits_ready), then at the next edge:
    - sbits = accumulator including the current beat;
    - sbits_valid = 1;
    - accumulator cleared; cluster counter cleared.
  - Otherwise go to WAIT.
- State WAIT: cluster_ready = 0; the accumulator holds the complete frame. When sbits_ready is seen with sbits_valid, transfer the accumulator to sbits on that edge, keep sbits_valid = 1, clear the accumulator, return to ACCUM.
- Output handshake:
  - sbits and sbits_valid are held stable until accepted.
  - sbits_valid drops the cycle after acceptance unless a new transfer occurs on the same edge.
- Latency: frame_end beat to sbits_valid = 1 clock when the buffer is free. Back-to-back frames are sustained at one beat per cycle with sbits_ready tied high.
- en low: no beat accepted; no state or output change; the overflow pulse is deferred.
- Empty frame (a single sentinel beat with frame_end): produces an all-zero bitmap with sbits_valid = 1.

Optional Feature:
- Macro: CLUSTER_EXPANDER_OVERLAP_CHECK_EN.
- Defined: if any bit painted by an accepted beat is already set in the accumulator, overlap latches to 1. It clears only on reset.
- Undefined: overlap is tied 0 and no comparison logic is built.

Decomposition:
- Package cluster_pkg:
  - NUM_SBITS, ADR_BITS, CNT_BITS, MAX_CLUSTERS defaults;
  - INVALID_ADR = 11'h7FF;
  - cluster_t packed struct {adr, cnt};
  - state enum {ACCUM, WAIT}.
- Sub-module cluster_mask_gen: combinational (adr, cnt) to NUM_SBITS-wide mask with clipping and sentinel handling. It is reused by the overlap check and by bench models.

Test Plan:
- Single beat adr=100, cnt=3, frame_end=1 -> next cycle sbits_valid=1, bits 100..103 set, all other bits 0.
- Beats (0,7), (1535,7), then (0x7FF,0) with frame_end -> bits 0..7 and bit 1535 only; no wrap.
- 17 beats adr=10*k, cnt=0, k=0..16, last with frame_end -> bits 0,10,...,150 set, bit 160 clear; overflow pulses 1 cycle.
- sbits_ready=0 while two frames end (adr 5, then adr 9) -> second frame_end accepted, then cluster_ready=0 (WAIT). Raise sbits_ready -> first map (bit 5) accepted, then second map (bit 9) presented the next cycle.
- reset_n=0 for 1 cycle after 3 beats without frame_end -> all outputs 0. Next frame (adr 42, cnt 0) yields only bit 42.
- With CLUSTER_EXPANDER_OVERLAP_CHECK_EN: beats (20,3) and (22,1) in one frame -> overlap=1 and stays 1 across frames. Without the macro -> overlap stays 0.

Source files
------------

// File: rtl/cluster_pkg.sv
// cluster_pkg: shared defaults and types for the cluster expander slice.
// Holds the bitmap geometry, the invalid-address sentinel, the encoded
// cluster beat layout and the expander state encoding.
package cluster_pkg;

  localparam int NUM_SBITS    = 1536;
  localparam int ADR_BITS     = 11;
  localparam int CNT_BITS     = 3;
  localparam int MAX_CLUSTERS = 16;

  // Address used by the cluster packer for "no cluster in this slot"
  localparam logic [ADR_BITS-1:0] INVALID_ADR = 11'h7FF;

  typedef struct packed {
    logic [ADR_BITS-1:0] adr;
    logic [CNT_BITS-1:0] cnt;
  } cluster_t;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    WAIT  = 1'b1
  } state_t;

endpackage

// File: rtl/cluster_mask_gen.sv
// cluster_mask_gen: combinational (adr, cnt) -> s-bit mask.
// Sets bits adr .. adr+cnt, clips anything at or above NUM_SBITS (no wrap),
// and yields an empty mask for any start address outside the map, which
// covers the invalid sentinel.
module cluster_mask_gen
  import cluster_pkg::*;
#(
  parameter int NUM_SBITS = cluster_pkg::NUM_SBITS,
  parameter int ADR_BITS  = cluster_pkg::ADR_BITS,
  parameter int CNT_BITS  = cluster_pkg::CNT_BITS
) (
  input  logic [ADR_BITS-1:0]  adr,
  input  logic [CNT_BITS-1:0]  cnt,
  output logic [NUM_SBITS-1:0] mask
);

  // One extra bit so adr+cnt cannot overflow past the top of the map
  localparam logic [ADR_BITS:0] LIMIT = NUM_SBITS[ADR_BITS:0];

  logic [ADR_BITS:0] first_bit;
  logic [ADR_BITS:0] last_bit;
  logic              adr_ok;

  assign first_bit = {1'b0, adr};
  assign last_bit  = first_bit + {{(ADR_BITS+1-CNT_BITS){1'b0}}, cnt};
  assign adr_ok    = first_bit < LIMIT;

  // Per-bit window test; bits above the map simply do not exist, which clips
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SBITS; gi++) begin : g_bit
      localparam logic [ADR_BITS:0] IDX = gi[ADR_BITS:0];
      assign mask[gi] = adr_ok && (IDX >= first_bit) && (IDX <= last_bit);
    end
  endgenerate

endmodule

// File: rtl/cluster_expander.sv
// cluster_expander: repaints a serial stream of (address, count) clusters
// for one bunch crossing into an s-bit bitmap, double-buffered behind a
// valid/ready handshake. The accumulator collects a frame while the output
// register holds the previous one.
// Optional build macro: CLUSTER_EXPANDER_OVERLAP_CHECK_EN enables the sticky
// overlap flag; without it overlap is tied low.
module cluster_expander
  import cluster_pkg::*;
#(
  parameter int NUM_SBITS    = cluster_pkg::NUM_SBITS,
  parameter int ADR_BITS     = cluster_pkg::ADR_BITS,
  parameter int CNT_BITS     = cluster_pkg::CNT_BITS,
  parameter int MAX_CLUSTERS = cluster_pkg::MAX_CLUSTERS
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 cluster_valid,
  output logic                 cluster_ready,
  input  logic [ADR_BITS-1:0]  cluster_adr,
  input  logic [CNT_BITS-1:0]  cluster_cnt,
  input  logic                 frame_end,
  output logic [NUM_SBITS-1:0] sbits,
  output logic                 sbits_valid,
  input  logic                 sbits_ready,
  output logic                 overflow,
  output logic                 overlap
);

  localparam int          CW       = $clog2(MAX_CLUSTERS + 1);
  localparam logic [0:0]  ST_ACCUM = 1'(ACCUM);
  localparam logic [0:0]  ST_WAIT  = 1'(WAIT);

  logic [0:0]           state_reg;
  logic [NUM_SBITS-1:0] acc_reg;
  logic [NUM_SBITS-1:0] sbits_reg;
  logic                 sbits_valid_reg;
  logic [CW-1:0]        cnt_reg;
  logic                 over_reg;
  logic                 overflow_reg;

  logic [NUM_SBITS-1:0] beat_mask;
  logic [NUM_SBITS-1:0] paint;
  logic [NUM_SBITS-1:0] acc_next;
  logic                 accept;
  logic                 drain;
  logic                 paint_ok;

  cluster_mask_gen #(
    .NUM_SBITS (NUM_SBITS),
    .ADR_BITS  (ADR_BITS),
    .CNT_BITS  (CNT_BITS)
  ) u_mask (
    .adr  (cluster_adr),
    .cnt  (cluster_cnt),
    .mask (beat_mask)
  );

  assign cluster_ready = (state_reg == ST_ACCUM);
  assign accept        = cluster_valid & cluster_ready & en;
  assign drain         = sbits_valid_reg & sbits_ready;
  // Counter saturates at MAX_CLUSTERS; beats past the limit paint nothing
  assign paint_ok      = cnt_reg < CW'(MAX_CLUSTERS);
  assign paint         = paint_ok ? beat_mask : '0;
  assign acc_next      = acc_reg | paint;

  assign sbits       = sbits_reg;
  assign sbits_valid = sbits_valid_reg;
  assign overflow    = overflow_reg;

  // Frame accumulation, output buffer hand-off and overflow tracking
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg       <= ST_ACCUM;
      acc_reg         <= '0;
      sbits_reg       <= '0;
      sbits_valid_reg <= 1'b0;
      cnt_reg         <= '0;
      over_reg        <= 1'b0;
      overflow_reg    <= 1'b0;
    end else if (en) begin
      // Pulse follows the frame_end beat; a limit hit on that beat counts too
      overflow_reg <= accept & frame_end & (over_reg | ~paint_ok);
      case (state_reg)
        ST_ACCUM: begin
          if (drain) sbits_valid_reg <= 1'b0;
          if (accept) begin
            if (frame_end) begin
              cnt_reg  <= '0;
              over_reg <= 1'b0;
              if (!sbits_valid_reg || sbits_ready) begin
                sbits_reg       <= acc_next;
                sbits_valid_reg <= 1'b1;
                acc_reg         <= '0;
              end else begin
                // Output still occupied: park the finished frame here
                acc_reg   <= acc_next;
                state_reg <= ST_WAIT;
              end
            end else begin
              acc_reg <= acc_next;
              if (paint_ok) cnt_reg  <= cnt_reg + CW'(1);
              else          over_reg <= 1'b1;
            end
          end
        end
        default: begin
          if (drain) begin
            sbits_reg       <= acc_reg;
            sbits_valid_reg <= 1'b1;
            acc_reg         <= '0;
            state_reg       <= ST_ACCUM;
          end
        end
      endcase
    end
  end

`ifdef CLUSTER_EXPANDER_OVERLAP_CHECK_EN
  logic overlap_reg;
  assign overlap = overlap_reg;

  // Sticky flag: a painted bit was already set in the current frame
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      overlap_reg <= 1'b0;
    end else if (en && accept && |(paint & acc_reg)) begin
      overlap_reg <= 1'b1;
    end
  end
`else
  assign overlap = 1'b0;
`endif

endmodule
